fpu_req_arbiter: RTL and testbench

Shares one FPU block between `NUM_REQS` requesters, such as issue slots or sub-warp sequencers. It does round-robin arbitration, allocates a tag to every accepted request and bounds each requester's in-flight requests with credits. Responses are routed back to the owning requester by tag. The block sits between the per-slot dispatch side and a single FPU block's `tag_in`/`tag_out` interface. It replaces the external tag store for multi-requester configurations.

---
 rtl/fpu_req_arbiter.sv | 234 +++++++++++++++++++++++
 tb/tb_fpu_req_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_req_arbiter.sv
// Purpose: shares one FPU among NUM_REQS requesters with round-robin grant, tag allocation, per-requester credits and response routing by tag.
// Latency: zero-cycle request and response paths (combinational from registered state); pool, credit and pointer updates land on the next clock.
// Backpressure: an FPU stall locks grant/tag/data until accepted; capped requesters and an empty pool are skipped; responses wait on the owner's rsp_ready.
module fpu_req_arbiter #(
  parameter int NUM_REQS    = 4,
  parameter int REQ_DATAW   = 64,
  parameter int RSP_DATAW   = 64,
  parameter int TAG_WIDTH   = 3,
  parameter int REQ_CREDITS = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQS-1:0]           req_valid,
  input  logic [NUM_REQS*REQ_DATAW-1:0] req_data,
  output logic [NUM_REQS-1:0]           req_ready,
  output logic                          fpu_req_valid,
  output logic [REQ_DATAW-1:0]          fpu_req_data,
  output logic [TAG_WIDTH-1:0]          fpu_req_tag,
  input  logic                          fpu_req_ready,
  input  logic                          fpu_rsp_valid,
  input  logic [TAG_WIDTH-1:0]          fpu_rsp_tag,
  input  logic [RSP_DATAW-1:0]          fpu_rsp_data,
  output logic                          fpu_rsp_ready,
  output logic [NUM_REQS-1:0]           rsp_valid,
  output logic [RSP_DATAW-1:0]          rsp_data,
  input  logic [NUM_REQS-1:0]           rsp_ready,
  output logic [TAG_WIDTH:0]            outstanding,
  output logic                          idle,
  output logic                          tag_err
);

  localparam int NTAGS = 1 << TAG_WIDTH;
  localparam int IDW   = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  localparam int CRW   = $clog2(REQ_CREDITS + 1);

  localparam logic [0:0]       S_IDLE   = 1'b0;
  localparam logic [0:0]       S_HOLD   = 1'b1;
  localparam logic [IDW-1:0]   LAST_ID  = IDW'(NUM_REQS - 1);
  localparam logic [CRW-1:0]   CRED_MAX = CRW'(REQ_CREDITS);
  localparam logic [CRW-1:0]   CRED_ONE = CRW'(1);
  localparam logic [TAG_WIDTH:0] CNT_ONE = (TAG_WIDTH+1)'(1);

  // Registered state
  logic [NTAGS-1:0]     r_free_mask;
  logic [IDW-1:0]       r_owner [NTAGS];
  logic [CRW-1:0]       r_credit [NUM_REQS];
  logic [IDW-1:0]       r_rr_ptr;
  logic [0:0]           r_state;
  logic [IDW-1:0]       r_hold_id;
  logic [TAG_WIDTH-1:0] r_hold_tag;
  logic                 r_tag_err;
  logic [TAG_WIDTH:0]   r_outstanding;

  // Combinational nets
  logic [REQ_DATAW-1:0] w_req_dat [NUM_REQS];
  logic [NUM_REQS-1:0]  w_elig;
  logic [IDW-1:0]       w_idx;
  logic [IDW-1:0]       w_rr_grant;
  logic                 w_rr_found;
  logic [TAG_WIDTH-1:0] w_free_tag;
  logic [IDW-1:0]       w_grant;
  logic [TAG_WIDTH-1:0] w_tag;
  logic                 w_req_vld;
  logic                 w_issue;
  logic                 w_rsp_alloc;
  logic [IDW-1:0]       w_rsp_owner;
  logic                 w_rsp_fire;
  logic                 w_rsp_bad;
  logic [NTAGS-1:0]     w_free_nxt;
  logic [TAG_WIDTH:0]   w_used_nxt;
  logic [NUM_REQS-1:0]  w_cr_inc;
  logic [NUM_REQS-1:0]  w_cr_dec;

  genvar g;
  generate
    for (g = 0; g < NUM_REQS; g++) begin : g_unpack
      assign w_req_dat[g] = req_data[g*REQ_DATAW +: REQ_DATAW];
    end
  endgenerate

  // A requester may compete only with a free credit and a free tag in the pool
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      w_elig[i] = req_valid[i] && (r_credit[i] < CRED_MAX) && (|r_free_mask);
    end
  end

  // Round-robin search: first eligible requester at or after r_rr_ptr, wrapping
  always_comb begin
    w_rr_grant = '0;
    w_rr_found = 1'b0;
    w_idx      = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      w_idx = IDW'((int'(r_rr_ptr) + k) % NUM_REQS);
      if (!w_rr_found && w_elig[w_idx]) begin
        w_rr_found = 1'b1;
        w_rr_grant = w_idx;
      end
    end
  end

  // Lowest free tag of the registered pool (a same-cycle release is not visible here)
  always_comb begin
    w_free_tag = '0;
    for (int t = NTAGS - 1; t >= 0; t--) begin
      if (r_free_mask[t]) w_free_tag = TAG_WIDTH'(t);
    end
  end

  // HOLD replays the latched grant and tag so the FPU sees a stable request
  always_comb begin
    w_grant   = (r_state == S_HOLD) ? r_hold_id  : w_rr_grant;
    w_tag     = (r_state == S_HOLD) ? r_hold_tag : w_free_tag;
    w_req_vld = (r_state == S_HOLD) ? 1'b1       : w_rr_found;
  end

  // Request-side outputs; reset forces them quiet regardless of requester inputs
  always_comb begin
    fpu_req_valid = reset && w_req_vld;
    fpu_req_tag   = w_tag;
    fpu_req_data  = w_req_dat[w_grant];
    req_ready     = '0;
    if (fpu_req_valid) req_ready[w_grant] = fpu_req_ready;
    w_issue       = fpu_req_valid && fpu_req_ready;
  end

  // Response routing by tag owner; unallocated tags are swallowed and flagged
  always_comb begin
    w_rsp_alloc   = !r_free_mask[fpu_rsp_tag];
    w_rsp_owner   = r_owner[fpu_rsp_tag];
    fpu_rsp_ready = reset && (w_rsp_alloc ? rsp_ready[w_rsp_owner] : 1'b1);
    rsp_valid     = '0;
    if (reset && w_rsp_alloc && fpu_rsp_valid) rsp_valid[w_rsp_owner] = 1'b1;
    rsp_data      = fpu_rsp_data;
    w_rsp_fire    = fpu_rsp_valid && fpu_rsp_ready && w_rsp_alloc;
    w_rsp_bad     = fpu_rsp_valid && !w_rsp_alloc;
  end

  // Next pool state: issue and release never touch the same tag (one is free, one allocated)
  always_comb begin
    w_free_nxt = r_free_mask;
    if (w_issue)    w_free_nxt[w_tag]       = 1'b0;
    if (w_rsp_fire) w_free_nxt[fpu_rsp_tag] = 1'b1;
    w_used_nxt = '0;
    for (int t = 0; t < NTAGS; t++) begin
      if (!w_free_nxt[t]) w_used_nxt = w_used_nxt + CNT_ONE;
    end
  end

  // Per-requester credit take (issue) and return (response)
  always_comb begin
    w_cr_inc = '0;
    w_cr_dec = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      w_cr_inc[i] = w_issue    && (w_grant     == IDW'(i));
      w_cr_dec[i] = w_rsp_fire && (w_rsp_owner == IDW'(i));
    end
  end

  // Tag pool, ownership and occupancy count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_free_mask   <= '1;
      r_outstanding <= '0;
      for (int t = 0; t < NTAGS; t++) r_owner[t] <= '0;
    end else begin
      r_free_mask   <= w_free_nxt;
      r_outstanding <= w_used_nxt;
      if (w_issue) r_owner[w_tag] <= w_grant;
    end
  end

  // Credits: simultaneous take and return on one requester cancel out
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REQS; i++) r_credit[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQS; i++) begin
        case ({w_cr_inc[i], w_cr_dec[i]})
          2'b10:   r_credit[i] <= r_credit[i] + CRED_ONE;
          2'b01:   r_credit[i] <= r_credit[i] - CRED_ONE;
          default: r_credit[i] <= r_credit[i];
        endcase
      end
    end
  end

  // Round-robin pointer moves past the requester that just issued
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr_ptr <= '0;
    end else if (w_issue) begin
      r_rr_ptr <= (w_grant == LAST_ID) ? '0 : w_grant + IDW'(1);
    end
  end

  // IDLE/HOLD FSM: a stalled grant is locked until the FPU accepts it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_hold_id  <= '0;
      r_hold_tag <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (fpu_req_valid && !fpu_req_ready) begin
            r_state    <= S_HOLD;
            r_hold_id  <= w_grant;
            r_hold_tag <= w_tag;
          end
        end
        S_HOLD: begin
          if (fpu_req_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Sticky flag for responses carrying a tag nobody owns
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tag_err <= 1'b0;
    end else if (w_rsp_bad) begin
      r_tag_err <= 1'b1;
    end
  end

  assign outstanding = r_outstanding;
  assign idle        = (r_outstanding == '0) && (r_state == S_IDLE);
  assign tag_err     = r_tag_err;

endmodule

// File: tb/tb_fpu_req_arbiter.sv
// Bench for fpu_req_arbiter: directed scenarios plus a randomized run, all
// checked every cycle against a behavioural model of the tag pool, credits and grant order.
module tb_fpu_req_arbiter;
  localparam int NR = 4;
  localparam int DW = 64;
  localparam int RW = 64;
  localparam int TW = 3;
  localparam int CR = 4;
  localparam int NT = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic              fpu_req_valid;
  logic [DW-1:0]     fpu_req_data;
  logic [TW-1:0]     fpu_req_tag;
  logic              fpu_req_ready;
  logic              fpu_rsp_valid;
  logic [TW-1:0]     fpu_rsp_tag;
  logic [RW-1:0]     fpu_rsp_data;
  logic              fpu_rsp_ready;
  logic [NR-1:0]     rsp_valid;
  logic [RW-1:0]     rsp_data;
  logic [NR-1:0]     rsp_ready;
  logic [TW:0]       outstanding;
  logic              idle;
  logic              tag_err;

  always #5 clk = ~clk;

  fpu_req_arbiter #(.NUM_REQS(NR), .REQ_DATAW(DW), .RSP_DATAW(RW), .TAG_WIDTH(TW), .REQ_CREDITS(CR)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .fpu_req_valid(fpu_req_valid), .fpu_req_data(fpu_req_data), .fpu_req_tag(fpu_req_tag),
    .fpu_req_ready(fpu_req_ready),
    .fpu_rsp_valid(fpu_rsp_valid), .fpu_rsp_tag(fpu_rsp_tag), .fpu_rsp_data(fpu_rsp_data),
    .fpu_rsp_ready(fpu_rsp_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .outstanding(outstanding), .idle(idle), .tag_err(tag_err)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Behavioural model: pool as a bit per tag, credits as plain counts
  bit m_free [NT];
  int m_owner [NT];
  int m_cred [NR];
  int m_rr;
  bit m_hold;
  int m_hold_id;
  int m_hold_tag;
  bit m_terr;
  int inflight[$];
  int gq[$];
  int tq[$];

  task automatic model_reset();
    for (int t = 0; t < NT; t++) m_free[t] = 1'b1;
    for (int i = 0; i < NR; i++) m_cred[i] = 0;
    m_rr = 0; m_hold = 1'b0; m_terr = 1'b0;
    inflight.delete(); gq.delete(); tq.delete();
  endtask

  task automatic idle_in();
    req_valid = '0; fpu_req_ready = 1'b0; fpu_rsp_valid = 1'b0;
    fpu_rsp_tag = '0; rsp_ready = '0;
  endtask

  task automatic want(input int i);
    if (!req_valid[i]) begin
      req_valid[i] = 1'b1;
      req_data[i*DW +: DW] = {$urandom, $urandom};
    end
  endtask

  task automatic chk_reset_outs(input string pfx);
    chk({pfx, "_fpu_req_valid"}, fpu_req_valid, 0);
    chk({pfx, "_req_ready"}, req_ready, 0);
    chk({pfx, "_rsp_valid"}, rsp_valid, 0);
    chk({pfx, "_fpu_rsp_ready"}, fpu_rsp_ready, 0);
    chk({pfx, "_outstanding"}, outstanding, 0);
    chk({pfx, "_idle"}, idle, 1);
    chk({pfx, "_tag_err"}, tag_err, 0);
  endtask

  // Called at a falling edge with inputs driven: check outputs, clock, advance model
  task automatic step();
    int nfree, grant, tg, o, rtag, i;
    bit vld, alloc, iss, fire;
    logic [NR-1:0] e_rr, e_rv;
    bit e_frr;
    #1;
    nfree = 0;
    for (int t = 0; t < NT; t++) if (m_free[t]) nfree++;
    grant = -1; tg = 0;
    if (m_hold) begin
      grant = m_hold_id; tg = m_hold_tag;
    end else begin
      for (int k = 0; k < NR; k++) begin
        i = (m_rr + k) % NR;
        if (grant < 0 && req_valid[i] && m_cred[i] < CR && nfree > 0) grant = i;
      end
      for (int t = NT - 1; t >= 0; t--) if (m_free[t]) tg = t;
    end
    vld = (grant >= 0);
    e_rr = '0;
    if (vld && fpu_req_ready) e_rr[grant] = 1'b1;
    rtag  = int'(fpu_rsp_tag);
    alloc = !m_free[rtag];
    o     = m_owner[rtag];
    e_frr = alloc ? rsp_ready[o] : 1'b1;
    e_rv  = '0;
    if (alloc && fpu_rsp_valid) e_rv[o] = 1'b1;
    chk("fpu_req_valid", fpu_req_valid, vld);
    if (vld) begin
      chk("fpu_req_tag", fpu_req_tag, tg);
      chk("fpu_req_data", fpu_req_data, req_data[grant*DW +: DW]);
    end
    chk("req_ready", req_ready, e_rr);
    chk("fpu_rsp_ready", fpu_rsp_ready, e_frr);
    chk("rsp_valid", rsp_valid, e_rv);
    if (fpu_rsp_valid) chk("rsp_data", rsp_data, fpu_rsp_data);
    chk("outstanding", outstanding, NT - nfree);
    chk("idle", idle, (nfree == NT) && !m_hold);
    chk("tag_err", tag_err, m_terr);
    iss  = vld && fpu_req_ready;
    fire = fpu_rsp_valid && alloc && rsp_ready[o];
    @(posedge clk);
    if (fpu_rsp_valid && !alloc) m_terr = 1'b1;
    if (fire) begin
      m_free[rtag] = 1'b1;
      m_cred[o]--;
      for (int j = 0; j < inflight.size(); j++) begin
        if (inflight[j] == rtag) begin
          inflight.delete(j);
          break;
        end
      end
    end
    if (iss) begin
      m_free[tg] = 1'b0; m_owner[tg] = grant; m_cred[grant]++;
      m_rr = (grant + 1) % NR;
      inflight.push_back(tg); gq.push_back(grant); tq.push_back(tg);
    end
    if (m_hold) begin
      if (fpu_req_ready) m_hold = 1'b0;
    end else if (vld && !fpu_req_ready) begin
      m_hold = 1'b1; m_hold_id = grant; m_hold_tag = tg;
    end
    @(negedge clk);
    if (iss) req_valid[grant] = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_in();
    @(negedge clk);
    model_reset();
    reset = 1'b1;
  endtask

  int exp_b0 [5] = '{0, 1, 2, 3, 0};
  int exp_b1 [4] = '{0, 2, 3, 0};
  logic [DW-1:0] d2;

  initial begin
    reset = 1'b1;
    req_data = '0; fpu_rsp_data = '0;
    idle_in();
    req_valid = 4'hF; fpu_rsp_valid = 1'b1;
    #1 reset = 1'b0;
    #1 chk_reset_outs("por");
    @(negedge clk);
    model_reset(); idle_in(); reset = 1'b1;

    // Single requester: four tags then credit stall, then tag 2 reuse
    fpu_req_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin want(0); step(); end
    chk("single_issues", tq.size(), 4);
    for (int k = 0; k < 4 && k < tq.size(); k++) chk("single_tag_order", tq[k], k);
    #1;
    chk("single_ready0_capped", req_ready[0], 0);
    chk("single_outstanding", outstanding, 4);
    fpu_rsp_valid = 1'b1; fpu_rsp_tag = 3'd2; fpu_rsp_data = {$urandom, $urandom}; rsp_ready = 4'b0001;
    step();
    fpu_rsp_valid = 1'b0; rsp_ready = '0;
    want(0); step();
    chk("single_issues_after", tq.size(), 5);
    if (tq.size() == 5) chk("single_reuse_tag", tq[4], 2);

    // Fairness with all requesters, then with requester 1 dropped
    do_reset();
    fpu_req_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin for (int i = 0; i < NR; i++) want(i); step(); end
    chk("fair_count", gq.size(), 5);
    for (int k = 0; k < 5 && k < gq.size(); k++) chk("fair_order", gq[k], exp_b0[k]);
    do_reset();
    fpu_req_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin want(0); want(2); want(3); step(); end
    chk("fair_drop_count", gq.size(), 4);
    for (int k = 0; k < 4 && k < gq.size(); k++) chk("fair_drop_order", gq[k], exp_b1[k]);

    // Backpressure: requester 2 locked while the FPU stalls, requester 0 waits
    do_reset();
    want(2); d2 = req_data[2*DW +: DW];
    for (int c = 0; c < 3; c++) begin
      if (c > 0) want(0);
      step();
      #1;
      chk("bp_valid", fpu_req_valid, 1);
      chk("bp_tag", fpu_req_tag, 0);
      chk("bp_data", fpu_req_data, d2);
    end
    fpu_req_ready = 1'b1;
    step(); step();
    chk("bp_count", gq.size(), 2);
    if (gq.size() == 2) begin chk("bp_first", gq[0], 2); chk("bp_second", gq[1], 0); end

    // Same-cycle collision: tag 5 (owner 1) returns while requester 1 issues
    do_reset();
    fpu_req_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin want(0); step(); end
    for (int c = 0; c < 2; c++) begin want(1); step(); end
    #1 chk("coll_pre_outstanding", outstanding, 6);
    want(1);
    fpu_rsp_valid = 1'b1; fpu_rsp_tag = 3'd5; fpu_rsp_data = {$urandom, $urandom}; rsp_ready = 4'b0010;
    step();
    fpu_rsp_valid = 1'b0; rsp_ready = '0;
    chk("coll_tag_not_reused", tq[tq.size()-1], 6);
    #1 chk("coll_outstanding", outstanding, 6);
    want(1); step();
    chk("coll_next_tag", tq[tq.size()-1], 5);
    want(1); step();
    chk("coll_last_tag", tq[tq.size()-1], 7);
    fpu_rsp_valid = 1'b1; fpu_rsp_tag = 3'd5; rsp_ready = 4'b1101;
    #1;
    chk("coll_owner_route", rsp_valid, 4'b0010);
    chk("coll_owner_ready", fpu_rsp_ready, 0);
    fpu_rsp_tag = 3'd0; rsp_ready = 4'b0001; want(1);
    step();
    fpu_rsp_valid = 1'b0; rsp_ready = '0;
    step();
    #1 chk("coll_credit_cap", req_ready[1], 0);

    // Reset mid-operation: six outstanding and a held grant
    do_reset();
    fpu_req_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin want(0); step(); end
    for (int c = 0; c < 2; c++) begin want(1); step(); end
    want(2); fpu_req_ready = 1'b0;
    step();
    fpu_rsp_valid = 1'b1; fpu_rsp_tag = 3'd1; rsp_ready = 4'hF;
    #2 reset = 1'b0;
    #1 chk_reset_outs("mid");
    @(negedge clk);
    model_reset(); idle_in(); reset = 1'b1;
    step();

    // Unallocated response tag
    fpu_rsp_valid = 1'b1; fpu_rsp_tag = 3'd7; rsp_ready = '0;
    #1;
    chk("bad_rsp_ready", fpu_rsp_ready, 1);
    chk("bad_rsp_valid", rsp_valid, 0);
    step();
    fpu_rsp_valid = 1'b0;
    #1 chk("bad_tag_err", tag_err, 1);
    step(); step();
    chk("bad_tag_err_sticky", tag_err, 1);

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NR; i++) if ($urandom_range(0, 99) < 40) want(i);
      fpu_req_ready = ($urandom_range(0, 99) < 70);
      rsp_ready = 4'($urandom);
      fpu_rsp_data = {$urandom, $urandom};
      if (inflight.size() > 0 && $urandom_range(0, 99) < 50) begin
        fpu_rsp_valid = 1'b1;
        fpu_rsp_tag = TW'(inflight[$urandom_range(0, inflight.size() - 1)]);
      end else if ($urandom_range(0, 199) == 0) begin
        fpu_rsp_valid = 1'b1;
        fpu_rsp_tag = TW'($urandom_range(0, NT - 1));
      end else begin
        fpu_rsp_valid = 1'b0;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
